// File: rtl/nexus_pifo_pkg.sv
// nexus_pifo_pkg
// Shared definitions for the Nexus PIFO shared-SRAM management blocks
// (free-block list and elastic allocator).
//   - Fail codes reported on allocation responses.
//   - FSM state encoding for the free-block list.
//   - Default tenant / block geometry shared between blocks.
package nexus_pifo_pkg;

  localparam int DEF_SRAM_BLOCKS = 1024;
  localparam int DEF_ADW         = 10;
  localparam int DEF_TENANTS     = 16;
  localparam int DEF_TW          = 4;

  localparam logic [1:0] FAIL_NONE  = 2'd0;
  localparam logic [1:0] FAIL_EMPTY = 2'd1;
  localparam logic [1:0] FAIL_QUOTA = 2'd2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fl_state_e;

endpackage

// File: rtl/nexus_free_fifo.sv
// nexus_free_fifo
// Circular buffer of free block addresses: one write port, one read port,
// registered read data and an occupancy count.
// Ports:
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   push, push_data : write push_data at the tail
//   pop             : read entry at the head into pop_data (next cycle)
//   pop_data        : registered read data
//   count           : number of valid entries (AW+1 bits)
// The caller guarantees no push when full and no pop when empty.
module nexus_free_fifo #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          push,
  input  logic [AW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] pop_data,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [AW-1:0] mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  // Pointers wrap naturally because DEPTH is 2**AW.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head     <= head + PTR_ONE;
        pop_data <= mem[head];
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is plain SRAM: no reset, contents rebuilt by the INIT sweep.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

endmodule

// File: rtl/nexus_block_free_list.sv
// nexus_block_free_list
// Free-block manager for the Nexus PIFO shared SRAM. After reset it sweeps
// every block address into the free FIFO (INIT), then serves allocation
// requests and block returns (RUN) while enforcing per-tenant quotas.
// Ports:
//   i_clk, i_arst_n       : clock, asynchronous active-low reset
//   i_alloc_valid/tenant  : allocation request, o_alloc_ready accepts it
//   o_rsp_valid/addr/fail/code : one-cycle response, one cycle after accept
//   i_free_valid/addr/tenant   : block return (no backpressure)
//   i_quota_wr/tenant/val : per-tenant quota write
//   o_init_done           : pool fully populated
//   o_free_count          : blocks currently free
//   o_err                 : pulse, one cycle after an illegal free
// Optional: NEXUS_FREE_DOUBLE_FREE_CHECK_EN adds an allocated-block bitmap
// that rejects frees of blocks that are not currently allocated.
module nexus_block_free_list
  import nexus_pifo_pkg::*;
#(
  parameter int SRAM_BLOCKS = DEF_SRAM_BLOCKS,
  parameter int ADW         = DEF_ADW,
  parameter int TENANTS     = DEF_TENANTS,
  parameter int TW          = DEF_TW
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic           i_alloc_valid,
  input  logic [TW-1:0]  i_alloc_tenant,
  output logic           o_alloc_ready,
  output logic           o_rsp_valid,
  output logic [ADW-1:0] o_rsp_addr,
  output logic           o_rsp_fail,
  output logic [1:0]     o_rsp_code,
  input  logic           i_free_valid,
  input  logic [ADW-1:0] i_free_addr,
  input  logic [TW-1:0]  i_free_tenant,
  input  logic           i_quota_wr,
  input  logic [TW-1:0]  i_quota_tenant,
  input  logic [ADW:0]   i_quota_val,
  output logic           o_init_done,
  output logic [ADW:0]   o_free_count,
  output logic           o_err
);

  localparam logic [ADW-1:0] LAST_IDX = ADW'(SRAM_BLOCKS - 1);
  localparam logic [ADW-1:0] IDX_ONE  = ADW'(1);
  localparam logic [ADW:0]   FULL_CNT = (ADW+1)'(SRAM_BLOCKS);
  localparam logic [ADW:0]   CNT_ONE  = (ADW+1)'(1);

  fl_state_e      state, state_nxt;
  logic [ADW-1:0] init_cnt;

  logic [ADW:0]   usage [TENANTS];
  logic [ADW:0]   quota [TENANTS];

  logic           run;
  logic           alloc_fire;
  logic           alloc_ok;
  logic [1:0]     alloc_code;
  logic           free_fire;
  logic           free_bad;
  logic           free_ok;
  logic           in_use;

  logic           fifo_push;
  logic [ADW-1:0] fifo_wdata;
  logic [ADW-1:0] fifo_rdata;
  logic [ADW:0]   free_cnt;

  logic           rsp_valid;
  logic           rsp_fail;
  logic [1:0]     rsp_code;
  logic           rsp_ok;
  logic           err;

  nexus_free_fifo #(
    .DEPTH (SRAM_BLOCKS),
    .AW    (ADW)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_arst_n  (i_arst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (alloc_ok),
    .pop_data  (fifo_rdata),
    .count     (free_cnt)
  );

`ifdef NEXUS_FREE_DOUBLE_FREE_CHECK_EN
  logic [SRAM_BLOCKS-1:0] alloc_map;

  // The popped address only becomes visible in the response cycle, so the
  // bitmap is set then; the bypass covers a free arriving in that same cycle.
  assign in_use = alloc_map[i_free_addr] || (rsp_ok && (fifo_rdata == i_free_addr));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      alloc_map <= '0;
    end else begin
      if (rsp_ok) begin
        alloc_map[fifo_rdata] <= 1'b1;
      end
      if (free_ok) begin
        alloc_map[i_free_addr] <= 1'b0;
      end
    end
  end
`else
  assign in_use = 1'b1;
`endif

  // All checks use pre-cycle state: no bypass of a same-cycle free into
  // the empty check, and same-cycle quota writes are not yet visible.
  always_comb begin
    run        = (state == ST_RUN);
    alloc_fire = i_alloc_valid && run;
    alloc_code = FAIL_NONE;
    if (free_cnt == '0) begin
      alloc_code = FAIL_EMPTY;
    end else if (usage[i_alloc_tenant] >= quota[i_alloc_tenant]) begin
      alloc_code = FAIL_QUOTA;
    end
    alloc_ok   = alloc_fire && (alloc_code == FAIL_NONE);

    free_fire  = i_free_valid && run;
    free_bad   = (usage[i_free_tenant] == '0) || (free_cnt == FULL_CNT) || !in_use;
    free_ok    = free_fire && !free_bad;

    fifo_push  = run ? free_ok : 1'b1;
    fifo_wdata = run ? i_free_addr : init_cnt;

    state_nxt  = state;
    if ((state == ST_INIT) && (init_cnt == LAST_IDX)) begin
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + IDX_ONE;
      end
    end
  end

  // A same-tenant alloc and free in one cycle cancel out.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int t = 0; t < TENANTS; t++) begin
        usage[t] <= '0;
        quota[t] <= FULL_CNT;
      end
    end else begin
      for (int t = 0; t < TENANTS; t++) begin
        if (alloc_ok && (i_alloc_tenant == TW'(t)) &&
            !(free_ok && (i_free_tenant == TW'(t)))) begin
          usage[t] <= usage[t] + CNT_ONE;
        end else if (free_ok && (i_free_tenant == TW'(t)) &&
                     !(alloc_ok && (i_alloc_tenant == TW'(t)))) begin
          usage[t] <= usage[t] - CNT_ONE;
        end
      end
      if (i_quota_wr) begin
        quota[i_quota_tenant] <= i_quota_val;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rsp_valid <= 1'b0;
      rsp_fail  <= 1'b0;
      rsp_code  <= FAIL_NONE;
      rsp_ok    <= 1'b0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= alloc_fire;
      rsp_fail  <= alloc_fire && (alloc_code != FAIL_NONE);
      rsp_code  <= alloc_fire ? alloc_code : FAIL_NONE;
      rsp_ok    <= alloc_ok;
      err       <= free_fire && free_bad;
    end
  end

  assign o_alloc_ready = run;
  assign o_init_done   = run;
  assign o_rsp_valid   = rsp_valid;
  assign o_rsp_fail    = rsp_fail;
  assign o_rsp_code    = rsp_code;
  assign o_rsp_addr    = rsp_ok ? fifo_rdata : '0;
  assign o_free_count  = free_cnt;
  assign o_err         = err;

endmodule

// File: tb/tb_nexus_block_free_list.sv
// tb_nexus_block_free_list
// Directed plus randomized checks of nexus_block_free_list against a
// queue-based model of the free pool, per-tenant usage and quotas.
module tb_nexus_block_free_list;

  localparam int NB = 1024;

  logic        i_clk = 1'b0;
  logic        i_arst_n = 1'b0;
  logic        i_alloc_valid = 1'b0;
  logic [3:0]  i_alloc_tenant = '0;
  logic        o_alloc_ready;
  logic        o_rsp_valid;
  logic [9:0]  o_rsp_addr;
  logic        o_rsp_fail;
  logic [1:0]  o_rsp_code;
  logic        i_free_valid = 1'b0;
  logic [9:0]  i_free_addr = '0;
  logic [3:0]  i_free_tenant = '0;
  logic        i_quota_wr = 1'b0;
  logic [3:0]  i_quota_tenant = '0;
  logic [10:0] i_quota_val = '0;
  logic        o_init_done;
  logic [10:0] o_free_count;
  logic        o_err;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  typedef struct { int addr; int ten; } blk_t;
  int   fl[$];
  blk_t outs[$];
  int   usage_m [16];
  int   quota_m [16];
  bit   alloc_m [NB];
  int   last_addr;

  nexus_block_free_list dut (
    .i_clk          (i_clk),
    .i_arst_n       (i_arst_n),
    .i_alloc_valid  (i_alloc_valid),
    .i_alloc_tenant (i_alloc_tenant),
    .o_alloc_ready  (o_alloc_ready),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_addr     (o_rsp_addr),
    .o_rsp_fail     (o_rsp_fail),
    .o_rsp_code     (o_rsp_code),
    .i_free_valid   (i_free_valid),
    .i_free_addr    (i_free_addr),
    .i_free_tenant  (i_free_tenant),
    .i_quota_wr     (i_quota_wr),
    .i_quota_tenant (i_quota_tenant),
    .i_quota_val    (i_quota_val),
    .o_init_done    (o_init_done),
    .o_free_count   (o_free_count),
    .o_err          (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    outs.delete();
    for (int i = 0; i < NB; i++) begin
      fl.push_back(i);
      alloc_m[i] = 1'b0;
    end
    for (int t = 0; t < 16; t++) begin
      usage_m[t] = 0;
      quota_m[t] = NB;
    end
  endtask

  task automatic idle_inputs();
    i_alloc_valid = 1'b0;
    i_free_valid  = 1'b0;
    i_quota_wr    = 1'b0;
  endtask

  // One RUN cycle: drive, advance the model, then compare after the edge.
  task automatic step(input bit av, input int at, input bit fv, input int fa,
                      input int ft, input bit qw, input int qt, input int qv);
    int exp_code;
    int exp_addr;
    bit f_ok;
    i_alloc_valid  = av;
    i_alloc_tenant = 4'(at);
    i_free_valid   = fv;
    i_free_addr    = 10'(fa);
    i_free_tenant  = 4'(ft);
    i_quota_wr     = qw;
    i_quota_tenant = 4'(qt);
    i_quota_val    = 11'(qv);

    f_ok = fv && (usage_m[ft] != 0) && (fl.size() != NB);
`ifdef NEXUS_FREE_DOUBLE_FREE_CHECK_EN
    f_ok = f_ok && alloc_m[fa];
`endif
    exp_code = 0;
    exp_addr = 0;
    if (av) begin
      if (fl.size() == 0) exp_code = 1;
      else if (usage_m[at] >= quota_m[at]) exp_code = 2;
      else begin
        exp_addr = fl.pop_front();
        usage_m[at]++;
        alloc_m[exp_addr] = 1'b1;
        outs.push_back('{exp_addr, at});
      end
    end
    if (f_ok) begin
      fl.push_back(fa);
      usage_m[ft]--;
      alloc_m[fa] = 1'b0;
      for (int i = 0; i < outs.size(); i++) begin
        if (outs[i].addr == fa) begin
          outs.delete(i);
          break;
        end
      end
    end
    if (qw) quota_m[qt] = qv;
    last_addr = exp_addr;

    @(posedge i_clk);
    #1;
    check("rsp_valid", o_rsp_valid, av);
    if (av) begin
      check("rsp_fail", o_rsp_fail, exp_code != 0);
      check("rsp_code", o_rsp_code, exp_code);
      check("rsp_addr", o_rsp_addr, exp_addr);
    end
    check("err", o_err, fv && !f_ok);
    check("free_count", o_free_count, fl.size());
    check("alloc_ready", o_alloc_ready, 1);
    idle_inputs();
  endtask

  task automatic apply_reset();
    i_arst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_alloc_ready", o_alloc_ready, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_rsp_addr", o_rsp_addr, 0);
    check("rst_rsp_fail", o_rsp_fail, 0);
    check("rst_rsp_code", o_rsp_code, 0);
    check("rst_init_done", o_init_done, 0);
    check("rst_free_count", o_free_count, 0);
    check("rst_err", o_err, 0);
    #20;
    @(negedge i_clk);
    i_arst_n = 1'b1;
  endtask

  // Counts edges after reset release until init_done, with requests and
  // frees held active to show they are ignored during INIT.
  task automatic wait_init();
    int n;
    bit seen_rsp = 0;
    bit seen_err = 0;
    bit seen_rdy = 0;
    i_alloc_valid  = 1'b1;
    i_alloc_tenant = 4'd0;
    i_free_valid   = 1'b1;
    i_free_addr    = 10'd5;
    i_free_tenant  = 4'd0;
    for (n = 1; n <= 2000; n++) begin
      @(posedge i_clk);
      #1;
      if (o_init_done) break;
      if (o_rsp_valid) seen_rsp = 1;
      if (o_err) seen_err = 1;
      if (o_alloc_ready) seen_rdy = 1;
      if (n == 500) check("init_count_500", o_free_count, 500);
    end
    idle_inputs();
    check("init_cycles", n, NB);
    check("init_no_rsp", seen_rsp, 0);
    check("init_no_err", seen_err, 0);
    check("init_not_ready", seen_rdy, 0);
    check("init_free_count", o_free_count, NB);
    model_reset();
  endtask

  initial begin
    int t1_blk [4];
    int t3_first;

    $display("[TB] reset and initial population");
    apply_reset();
    wait_init();

    $display("[TB] drain the pool with tenant 0");
    for (int i = 0; i < NB; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    check("drained_count", o_free_count, 0);

    $display("[TB] empty pool with same-cycle free");
    step(1, 0, 1, 5, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("realloc_5", last_addr, 5);

    $display("[TB] tenant quota");
    for (int a = 10; a < 20; a++) step(0, 0, 1, a, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3, 2);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    t3_first = last_addr;
    step(1, 3, 0, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, t3_first, 3, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);

    $display("[TB] same-cycle alloc and free for one tenant");
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0);
      t1_blk[i] = last_addr;
    end
    step(1, 1, 1, t1_blk[0], 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 5);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);

    $display("[TB] illegal frees");
    step(0, 0, 1, 100, 7, 0, 0, 0);
`ifdef NEXUS_FREE_DOUBLE_FREE_CHECK_EN
    step(0, 0, 1, t3_first, 0, 0, 0, 0);
`endif

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      bit av, fv, qw;
      int at, fa, ft, qt, qv, r;
      av = ($urandom_range(0, 9) < 6);
      at = $urandom_range(0, 7);
      fv = 0; fa = 0; ft = 0;
      r  = $urandom_range(0, 9);
      if (r < 5 && outs.size() > 0) begin
        int k;
        k  = $urandom_range(0, outs.size() - 1);
        fv = 1; fa = outs[k].addr; ft = outs[k].ten;
      end else if (r == 5) begin
        fv = 1; fa = $urandom_range(0, NB - 1); ft = 15;
      end
      qw = ($urandom_range(0, 19) == 0);
      qt = $urandom_range(0, 7);
      qv = $urandom_range(0, 6);
      step(av, at, fv, fa, ft, qw, qt, qv);
    end

    $display("[TB] reset during INIT");
    apply_reset();
    repeat (500) @(posedge i_clk);
    #1;
    check("mid_init_count", o_free_count, 500);
    i_arst_n = 1'b0;
    #1;
    check("mid_init_rst_done", o_init_done, 0);
    check("mid_init_rst_count", o_free_count, 0);
    #20;
    @(negedge i_clk);
    i_arst_n = 1'b1;
    wait_init();
    step(1, 2, 0, 0, 0, 0, 0, 0);
    check("post_reinit_addr", last_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
